ifu_fetch_queue: RTL and testbench

Parametrised instruction fetch unit replacing the single-register IF/ID stage. Generates sequential PCs, issues pipelined requests to an instruction memory with variable response latency, buffers returned instructions in a DEPTH-entry FIFO, and hands them to decode over a valid/ready handshake. Redirects from branch resolution flush the queue and discard stale in-flight responses.

---
 rtl/ifu_fetch_queue_pkg.sv | 18 +
 rtl/ifu_fetch_queue_if.sv | 39 +++
 rtl/ifu_predecoder.sv | 17 +
 rtl/ifu_fetch_queue.sv | 129 ++++++++++++
 tb/tb_ifu_fetch_queue.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_fetch_queue_pkg.sv
// Shared widths, reset PC and predecoded field layout for the instruction fetch queue.
package ifu_fetch_queue_pkg;
  localparam int IFU_DATA_WIDTH = 32;
  localparam int OPCODE_WIDTH   = 7;
  localparam int ADDR_WIDTH     = 5;
  localparam int FUNC3_WIDTH    = 3;
  localparam int FUNC7_WIDTH    = 7;
  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0] op;
    logic [ADDR_WIDTH-1:0]   rd;
    logic [FUNC3_WIDTH-1:0]  func3;
    logic [ADDR_WIDTH-1:0]   rs1;
    logic [ADDR_WIDTH-1:0]   rs2;
    logic [FUNC7_WIDTH-1:0]  func7;
  } ifu_fields_t;
endpackage

// File: rtl/ifu_fetch_queue_if.sv
// Fetch-queue bus: imem request/response, redirect, and decode handshake.
// All handshakes: a transfer happens on a rising edge where valid && ready; imem responses have no ready.
interface ifu_fetch_queue_if
  import ifu_fetch_queue_pkg::*;
#(
  parameter int DATA_WIDTH = IFU_DATA_WIDTH
);
  logic                    imem_req_valid;
  logic                    imem_req_ready;
  logic [DATA_WIDTH-1:0]   imem_req_addr;
  logic                    imem_resp_valid;
  logic [DATA_WIDTH-1:0]   imem_resp_data;
  logic                    redirect_valid;
  logic [DATA_WIDTH-1:0]   redirect_pc;
  logic                    id_valid;
  logic                    id_ready;
  logic [DATA_WIDTH-1:0]   id_pc;
  logic [DATA_WIDTH-1:0]   id_instr;
  logic [OPCODE_WIDTH-1:0] id_op;
  logic [ADDR_WIDTH-1:0]   id_rs1;
  logic [ADDR_WIDTH-1:0]   id_rs2;
  logic [ADDR_WIDTH-1:0]   id_rd;
  logic [FUNC3_WIDTH-1:0]  id_func3;
  logic [FUNC7_WIDTH-1:0]  id_func7;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc, id_ready,
    output id_valid, id_pc, id_instr, id_op, id_rs1, id_rs2, id_rd, id_func3, id_func7
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc, id_ready,
    input  id_valid, id_pc, id_instr, id_op, id_rs1, id_rs2, id_rd, id_func3, id_func7
  );
endinterface

// File: rtl/ifu_predecoder.sv
// Combinational RV32 field extraction used at the enqueue or head point of the fetch queue.
module ifu_predecoder
  import ifu_fetch_queue_pkg::*;
(
  input  logic [31:0]  i_instr,
  output ifu_fields_t  o_fields
);
  always_comb begin
    o_fields       = '0;
    o_fields.op    = i_instr[6:0];
    o_fields.rd    = i_instr[11:7];
    o_fields.func3 = i_instr[14:12];
    o_fields.rs1   = i_instr[19:15];
    o_fields.rs2   = i_instr[24:20];
    o_fields.func7 = i_instr[31:25];
  end
endmodule

// File: rtl/ifu_fetch_queue.sv
// Instruction fetch queue: sequential PC generation, credit-limited imem requests, DEPTH-entry FIFO to decode.
// IFU_PREDECODE_EN: predecode at enqueue and store fields; otherwise decode the head combinationally.
module ifu_fetch_queue
  import ifu_fetch_queue_pkg::*;
#(
  parameter int                    DATA_WIDTH = IFU_DATA_WIDTH,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = IFU_RESET_PC
)(
  input  logic                         clk,
  input  logic                         rst_n,
  ifu_fetch_queue_if.master            bus,
  output logic [$clog2(DEPTH+1)-1:0]   o_dbg_count,
  output logic [$clog2(DEPTH+1)-1:0]   o_dbg_outstanding,
  output logic [$clog2(DEPTH+1)-1:0]   o_dbg_drop
);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);

  logic                  r_run;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [CNT_W-1:0]      r_count, r_out, r_drop;
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr, r_ip_wr, r_ip_rd;
  logic [DATA_WIDTH-1:0] r_q_pc    [DEPTH];
  logic [DATA_WIDTH-1:0] r_q_instr [DEPTH];
  logic [DATA_WIDTH-1:0] r_ip_pc   [DEPTH];

  logic                  w_req_valid, w_req_fire, w_resp_ok, w_enq, w_deq, w_head_valid;
  logic [CNT_W-1:0]      w_out_next;
  logic [DATA_WIDTH-1:0] w_id_pc, w_id_instr;
  ifu_fields_t           w_head_fields;

  // Credit: queued entries plus outstanding requests never exceed DEPTH, so the FIFO cannot overflow.
  assign w_req_valid  = r_run && !bus.redirect_valid &&
                        (({1'b0, r_count} + {1'b0, r_out}) < (CNT_W+1)'(DEPTH));
  assign w_req_fire   = w_req_valid && bus.imem_req_ready;
  assign w_resp_ok    = bus.imem_resp_valid && (r_out != '0);
  assign w_enq        = w_resp_ok && (r_drop == '0) && !bus.redirect_valid;
  assign w_head_valid = (r_count != '0);
  assign w_deq        = w_head_valid && bus.id_ready;
  assign w_out_next   = r_out + CNT_W'(w_req_fire) - CNT_W'(w_resp_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run    <= 1'b0;
      r_pc     <= RESET_PC;
      r_count  <= '0;
      r_out    <= '0;
      r_drop   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ip_wr  <= '0;
      r_ip_rd  <= '0;
    end else begin
      r_run <= 1'b1;
      r_out <= w_out_next;
      if (bus.redirect_valid) begin
        // Everything still in flight belongs to the old path.
        r_pc     <= bus.redirect_pc;
        r_drop   <= w_out_next;
        r_count  <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_ip_wr  <= '0;
        r_ip_rd  <= '0;
      end else begin
        if (w_req_fire) begin
          r_pc    <= r_pc + DATA_WIDTH'(4);
          r_ip_wr <= r_ip_wr + PTR_W'(1);
        end
        if (w_resp_ok && (r_drop != '0)) r_drop <= r_drop - CNT_W'(1);
        if (w_enq) begin
          r_ip_rd  <= r_ip_rd + PTR_W'(1);
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_req_fire) r_ip_pc[r_ip_wr] <= r_pc;
    if (w_enq) begin
      r_q_pc[r_wr_ptr]    <= r_ip_pc[r_ip_rd];
      r_q_instr[r_wr_ptr] <= bus.imem_resp_data;
    end
  end

  assign w_id_pc    = w_head_valid ? r_q_pc[r_rd_ptr]    : '0;
  assign w_id_instr = w_head_valid ? r_q_instr[r_rd_ptr] : '0;

`ifdef IFU_PREDECODE_EN
  ifu_fields_t w_enq_fields;
  ifu_fields_t r_q_fields [DEPTH];

  ifu_predecoder u_predecoder (
    .i_instr  (bus.imem_resp_data[31:0]),
    .o_fields (w_enq_fields)
  );

  always_ff @(posedge clk) begin
    if (w_enq) r_q_fields[r_wr_ptr] <= w_enq_fields;
  end

  assign w_head_fields = w_head_valid ? r_q_fields[r_rd_ptr] : '0;
`else
  ifu_predecoder u_predecoder (
    .i_instr  (w_id_instr[31:0]),
    .o_fields (w_head_fields)
  );
`endif

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_pc;
  assign bus.id_valid       = w_head_valid;
  assign bus.id_pc          = w_id_pc;
  assign bus.id_instr       = w_id_instr;
  assign bus.id_op          = w_head_fields.op;
  assign bus.id_rs1         = w_head_fields.rs1;
  assign bus.id_rs2         = w_head_fields.rs2;
  assign bus.id_rd          = w_head_fields.rd;
  assign bus.id_func3       = w_head_fields.func3;
  assign bus.id_func7       = w_head_fields.func7;

  assign o_dbg_count       = r_count;
  assign o_dbg_outstanding = r_out;
  assign o_dbg_drop        = r_drop;
endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Bench for ifu_fetch_queue: in-order variable-latency imem model, scoreboard of expected decode PCs.
module tb_ifu_fetch_queue;
  import ifu_fetch_queue_pkg::*;

  localparam logic [31:0] RST_PC   = 32'h8000_0000;
  localparam logic [31:0] ADD_PC   = 32'h8000_0100;
  localparam logic [31:0] ADD_INST = 32'h00B5_0533;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_count, dbg_out, dbg_drop;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  int n_fires = 0;
  int pop_first = -1;
  int pop_last = -1;
  logic [31:0] exp_next = RST_PC;
  logic [31:0] exp_q[$];

  typedef struct { int due; logic [31:0] addr; } mreq_t;
  mreq_t mq[$];

  ifu_fetch_queue_if #(.DATA_WIDTH(32)) bus ();

  ifu_fetch_queue #(.DATA_WIDTH(32), .DEPTH(4), .RESET_PC(RST_PC)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .bus               (bus.master),
    .o_dbg_count       (dbg_count),
    .o_dbg_outstanding (dbg_out),
    .o_dbg_drop        (dbg_drop)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == ADD_PC) return ADD_INST;
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // imem model: in order, fixed latency per phase, cleared with reset
  initial begin
    logic        s_fire;
    logic [31:0] s_addr;
    bus.imem_req_ready  = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    forever begin
      @(negedge clk);
      s_fire = rst_n && bus.imem_req_valid && bus.imem_req_ready;
      s_addr = bus.imem_req_addr;
      if (rst_n && bus.imem_resp_valid) check("solicited_resp", 32'(dbg_out != 3'd0), 32'd1);
      @(posedge clk);
      if (rst_n && s_fire) begin
        mq.push_back('{cyc + lat, s_addr});
        n_fires++;
      end
      #1;
      if (!rst_n) mq.delete();
      if (rst_n && mq.size() > 0 && mq[0].due <= cyc) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = mem_data(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        bus.imem_resp_valid = 1'b0;
      end
    end
  end

  always @(negedge rst_n) begin
    mq.delete();
    bus.imem_resp_valid = 1'b0;
  end

  // monitor: every decode handshake pops one expected PC
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.id_valid && bus.id_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_deq: got pc 0x%08h expected none", bus.id_pc);
        end else begin
          e = exp_q.pop_front();
          check("id_pc", bus.id_pc, e);
          check("id_instr", bus.id_instr, mem_data(e));
          if (e == ADD_PC) begin
            check("add_op", 32'(bus.id_op), 32'h33);
            check("add_rs1", 32'(bus.id_rs1), 32'd10);
            check("add_rs2", 32'(bus.id_rs2), 32'd11);
            check("add_rd", 32'(bus.id_rd), 32'd10);
            check("add_func3", 32'(bus.id_func3), 32'd0);
            check("add_func7", 32'(bus.id_func7), 32'd0);
          end
          if (pop_first < 0) pop_first = cyc;
          pop_last = cyc;
        end
      end
    end
  end

  // driver tasks (inputs change at posedge + 2)
  task automatic do_reset(input int l);
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.id_ready = 1'b0;
    lat = l;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2;
    n_fires = 0;
    exp_next = RST_PC;
    rst_n = 1'b1;
  endtask

  task automatic consume(input int n);
    int budget;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(exp_next);
      exp_next = exp_next + 32'd4;
    end
    pop_first = -1;
    bus.id_ready = 1'b1;
    budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      @(posedge clk);
      #2;
      budget++;
    end
    bus.id_ready = 1'b0;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL consume_timeout: got %0d left expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_state(input string name, input logic [2:0] cnt, input logic [2:0] out);
    int budget;
    budget = 0;
    while (!(dbg_count == cnt && dbg_out == out) && budget < 50) begin
      @(posedge clk);
      #2;
      budget++;
    end
    check(name, 32'(budget < 50), 32'd1);
  endtask

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.id_ready = 1'b0;

    // reset values
    @(negedge clk);
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("rst_id_valid", 32'(bus.id_valid), 32'd0);
    check("rst_id_pc", bus.id_pc, 32'd0);
    check("rst_id_instr", bus.id_instr, 32'd0);
    check("rst_id_op", 32'(bus.id_op), 32'd0);
    check("rst_count", 32'(dbg_count), 32'd0);

    // hold decode: exactly DEPTH requests, then steady stream
    do_reset(1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("hold_fires", 32'(n_fires), 32'd4);
    check("hold_count", 32'(dbg_count), 32'd4);
    check("hold_out", 32'(dbg_out), 32'd0);
    check("hold_req_valid", 32'(bus.imem_req_valid), 32'd0);
    @(posedge clk);
    #2;
    consume(8);
    check("throughput", 32'(pop_last - pop_first), 32'd7);

    // latency 3: redirect with 3 outstanding, first stale response arrives with the redirect
    do_reset(3);
    bus.id_ready = 1'b0;
    wait_state("reach_out3", 3'd0, 3'd3);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = ADD_PC;
    @(posedge clk);
    #2;
    bus.redirect_valid = 1'b0;
    exp_next = ADD_PC;
    @(negedge clk);
    check("redir_id_valid", 32'(bus.id_valid), 32'd0);
    check("redir_drop", 32'(dbg_drop), 32'd2);
    check("redir_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("redir_req_addr", bus.imem_req_addr, ADD_PC);
    @(posedge clk);
    #2;
    consume(3);

    // redirect + response + dequeue with entries+outstanding at DEPTH
    do_reset(1);
    wait_state("reach_full", 3'd4, 3'd0);
    exp_q.push_back(RST_PC);
    bus.id_ready = 1'b1;
    @(posedge clk);
    #2;
    bus.id_ready = 1'b0;
    @(posedge clk);
    #2;
    check("pre_count", 32'(dbg_count), 32'd3);
    check("pre_out", 32'(dbg_out), 32'd1);
    check("pre_resp", 32'(bus.imem_resp_valid), 32'd1);
    exp_q.push_back(RST_PC + 32'd4);
    bus.id_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h8000_0200;
    @(posedge clk);
    #2;
    bus.redirect_valid = 1'b0;
    bus.id_ready = 1'b0;
    exp_next = 32'h8000_0200;
    @(negedge clk);
    check("full_redir_id_valid", 32'(bus.id_valid), 32'd0);
    check("full_redir_count", 32'(dbg_count), 32'd0);
    check("full_redir_drop", 32'(dbg_drop), 32'd0);
    check("full_redir_out", 32'(dbg_out), 32'd0);
    check("full_redir_addr", bus.imem_req_addr, 32'h8000_0200);
    check("full_redir_exp_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #2;
    consume(3);

    // asynchronous reset with requests in flight
    do_reset(3);
    repeat (3) @(posedge clk);
    #2;
    check("mid_out_nonzero", 32'(dbg_out != 3'd0), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("arst_id_valid", 32'(bus.id_valid), 32'd0);
    check("arst_id_pc", bus.id_pc, 32'd0);
    check("arst_count", 32'(dbg_count), 32'd0);
    check("arst_out", 32'(dbg_out), 32'd0);
    check("arst_req_addr", bus.imem_req_addr, RST_PC);
    do_reset(2);
    consume(4);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
